// File: rtl/tx_sched_pkg.sv
// -----------------------------------------------------------------------------
// tx_sched_pkg
//   Shared definitions for the TX byte scheduler: default byte and ALU widths,
//   the scheduler FSM state type and the enqueue sizing helper.
// -----------------------------------------------------------------------------
package tx_sched_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ALU_WIDTH  = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    // FIFO entries an incoming item needs. An ALU result always wins the
    // write port, so a simultaneous register item is not counted here.
    function automatic logic [1:0] bytes_needed(input logic alu_v, input logic reg_v);
        if (alu_v) begin
            return 2'd2;
        end else if (reg_v) begin
            return 2'd1;
        end
        return 2'd0;
    endfunction

endpackage

// File: rtl/tx_sched_fifo.sv
// -----------------------------------------------------------------------------
// tx_sched_fifo
//   Synchronous FIFO with a two-lane write port and a single read port.
//   Lane 0 is always written first, so i_wr_en is 2'b00, 2'b01 or 2'b11.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     i_wr_en[1:0]  per-lane write enables (lane 0 lands at the write pointer)
//     i_wr_data     {lane1, lane0} write data
//     i_rd_en       pop the head entry (caller guarantees the FIFO is not empty)
//     o_rd_data     current head entry
//     o_count       number of stored entries
//     o_full        registered: fewer than 2 free entries
// -----------------------------------------------------------------------------
module tx_sched_fifo #(
    parameter int DW    = tx_sched_pkg::DATA_WIDTH,
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      i_wr_en,
    input  logic [2*DW-1:0] i_wr_data,
    input  logic            i_rd_en,
    output logic [DW-1:0]   o_rd_data,
    output logic [CW-1:0]   o_count,
    output logic            o_full
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full;

    logic [1:0]    w_wr_num;
    logic [CW-1:0] w_count_next;
    logic [PW-1:0] w_lane_ptr [2];

    assign w_wr_num     = {1'b0, i_wr_en[0]} + {1'b0, i_wr_en[1]};
    assign w_count_next = r_count + CW'(w_wr_num) - CW'(i_rd_en);

    // Lane addresses wrap naturally because DEPTH is a power of two.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            assign w_lane_ptr[gi] = r_wr_ptr + PW'(gi);
        end
    endgenerate

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (i_wr_en[i]) begin
                r_mem[w_lane_ptr[i]] <= i_wr_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_wr_num);
            r_rd_ptr <= r_rd_ptr + PW'(i_rd_en);
            r_count  <= w_count_next;
            r_full   <= (w_count_next > CW'(DEPTH - 2));
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_full    = r_full;

endmodule

// File: rtl/tx_byte_scheduler.sv
// -----------------------------------------------------------------------------
// tx_byte_scheduler
//   Queues ALU results (split into two bytes, low byte first) and register
//   read bytes, then hands them one at a time to UART TX with a level
//   tx_valid / tx_busy acknowledge handshake and a per-byte timeout.
//   Ports:
//     clk, rst                   clock, synchronous active-high reset
//     alu_out, alu_valid         ALU result and its 1-cycle strobe
//     reg_rd_data, reg_rd_valid  register read byte and its 1-cycle strobe
//     tx_busy                    synchronized UART TX busy flag
//     tx_p_data, tx_valid        byte offered to TX, held while tx_valid=1
//     clk_div_en                 TX clock divider enable (1-cycle latency)
//     fifo_full                  fewer than 2 free FIFO entries
//     drop_err                   1-cycle pulse: an incoming item was discarded
//     timeout_err                sticky handshake-timeout flag
// -----------------------------------------------------------------------------
module tx_byte_scheduler #(
    parameter int DATA_WIDTH  = tx_sched_pkg::DATA_WIDTH,
    parameter int ALU_WIDTH   = tx_sched_pkg::ALU_WIDTH,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ALU_WIDTH-1:0]  alu_out,
    input  logic                  alu_valid,
    input  logic [DATA_WIDTH-1:0] reg_rd_data,
    input  logic                  reg_rd_valid,
    input  logic                  tx_busy,
    output logic [DATA_WIDTH-1:0] tx_p_data,
    output logic                  tx_valid,
    output logic                  clk_div_en,
    output logic                  fifo_full,
    output logic                  drop_err,
    output logic                  timeout_err
);

    import tx_sched_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    // Enqueue arbitration
    logic [1:0]              w_need;
    logic [CW-1:0]           w_free;
    logic [CW-1:0]           w_count;
    logic                    w_take;
    logic                    w_drop;
    logic [1:0]              w_wr_en;
    logic [2*DATA_WIDTH-1:0] w_wr_data;
    logic [DATA_WIDTH-1:0]   w_head;

    // FSM and handshake
    state_t                  r_state;
    state_t                  w_state_next;
    logic [TW-1:0]           r_timer;
    logic [TW-1:0]           w_timer_next;
    logic                    w_pop;
    logic                    w_load;
    logic                    w_timeout_set;
    logic                    w_tx_valid_next;

    logic [DATA_WIDTH-1:0]   r_tx_p_data;
    logic                    r_tx_valid;
    logic                    r_clk_div_en;
    logic                    r_drop_err;
    logic                    r_timeout_err;

    // Free space is taken before any same-cycle pop, so a pop never makes
    // room for an item arriving in the same cycle. Items are all-or-nothing.
    assign w_need    = bytes_needed(alu_valid, reg_rd_valid);
    assign w_free    = CW'(FIFO_DEPTH) - w_count;
    assign w_take    = (w_need != 2'd0) && (CW'(w_need) <= w_free);
    assign w_drop    = (alu_valid && reg_rd_valid) || ((w_need != 2'd0) && !w_take);
    assign w_wr_en   = !w_take ? 2'b00 : ((w_need == 2'd2) ? 2'b11 : 2'b01);
    assign w_wr_data = alu_valid ? alu_out : {{DATA_WIDTH{1'b0}}, reg_rd_data};

    tx_sched_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_en),
        .i_wr_data (w_wr_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_count   (w_count),
        .o_full    (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_next;
            r_timer <= w_timer_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_timer_next    = r_timer;
        w_pop           = 1'b0;
        w_load          = 1'b0;
        w_timeout_set   = 1'b0;
        w_tx_valid_next = r_tx_valid;
        unique case (r_state)
            IDLE: begin
                w_timer_next = '0;
                // A busy flag still high from an earlier byte must not
                // acknowledge the next one, so wait for it to fall first.
                if ((w_count != '0) && !tx_busy) begin
                    w_state_next    = SEND;
                    w_load          = 1'b1;
                    w_tx_valid_next = 1'b1;
                end
            end
            SEND: begin
                if (tx_busy) begin
                    w_pop           = 1'b1;
                    w_tx_valid_next = 1'b0;
                    w_timer_next    = '0;
                    w_state_next    = WAIT_DONE;
                end else if (r_timer == TW'(TIMEOUT_CYC - 1)) begin
                    // The timed-out byte is discarded, not retried.
                    w_pop           = 1'b1;
                    w_tx_valid_next = 1'b0;
                    w_timer_next    = '0;
                    w_timeout_set   = 1'b1;
                    w_state_next    = IDLE;
                end else begin
                    w_timer_next = r_timer + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next    = IDLE;
                w_tx_valid_next = 1'b0;
                w_timer_next    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_p_data   <= '0;
            r_tx_valid    <= 1'b0;
            r_clk_div_en  <= 1'b0;
            r_drop_err    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_load) begin
                r_tx_p_data <= w_head;
            end
            r_tx_valid   <= w_tx_valid_next;
            r_clk_div_en <= (r_state != IDLE) || (w_count != '0);
            r_drop_err   <= w_drop;
            if (w_timeout_set) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign tx_p_data   = r_tx_p_data;
    assign tx_valid    = r_tx_valid;
    assign clk_div_en  = r_clk_div_en;
    assign drop_err    = r_drop_err;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_tx_byte_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tx_byte_scheduler
//   Self-checking bench for tx_byte_scheduler: reset state, a table of
//   per-cycle enqueue vectors, hand-written handshake sequences, and a
//   randomized run scored against a byte-queue model of the FIFO.
// -----------------------------------------------------------------------------
module tb_tx_byte_scheduler;

    localparam int DEPTH = 8;
    localparam int TMO   = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] alu_out = '0;
    logic        alu_valid = 1'b0;
    logic [7:0]  reg_rd_data = '0;
    logic        reg_rd_valid = 1'b0;
    logic        tx_busy = 1'b0;
    logic [7:0]  tx_p_data;
    logic        tx_valid;
    logic        clk_div_en;
    logic        fifo_full;
    logic        drop_err;
    logic        timeout_err;

    int checks = 0;
    int failures = 0;
    int rise_cnt = 0;
    int drop_cnt = 0;
    logic prev_valid = 1'b0;

    logic [7:0] got[$];
    logic [7:0] mq[$];

    int rphase = 0;
    int rdly = 0;
    int rhold = 0;

    always #5 clk = ~clk;

    tx_byte_scheduler #(
        .DATA_WIDTH  (8),
        .ALU_WIDTH   (16),
        .FIFO_DEPTH  (DEPTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_out      (alu_out),
        .alu_valid    (alu_valid),
        .reg_rd_data  (reg_rd_data),
        .reg_rd_valid (reg_rd_valid),
        .tx_busy      (tx_busy),
        .tx_p_data    (tx_p_data),
        .tx_valid     (tx_valid),
        .clk_div_en   (clk_div_en),
        .fifo_full    (fifo_full),
        .drop_err     (drop_err),
        .timeout_err  (timeout_err)
    );

    always @(negedge clk) begin
        if (tx_valid && !prev_valid) rise_cnt <= rise_cnt + 1;
        if (drop_err) drop_cnt <= drop_cnt + 1;
        prev_valid <= tx_valid;
    end

    typedef struct {
        logic        r;
        logic        av;
        logic [15:0] ad;
        logic        rv;
        logic [7:0]  rd;
        logic        e_drop;
        logic        e_full;
        logic        e_valid;
        logic        e_cde;
        logic [7:0]  e_data;
    } vec_t;

    vec_t tbl[14];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset(input logic busy_lvl);
        rst = 1'b1;
        alu_valid = 1'b0;
        reg_rd_valid = 1'b0;
        tx_busy = busy_lvl;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic push_alu(input logic [15:0] v);
        alu_out = v;
        alu_valid = 1'b1;
        tick;
        alu_valid = 1'b0;
    endtask

    task automatic push_reg(input logic [7:0] v);
        reg_rd_data = v;
        reg_rd_valid = 1'b1;
        tick;
        reg_rd_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int n = 0;
        while (!tx_valid && n < budget) begin
            tick;
            n++;
        end
        chk(name, tx_valid, 1);
    endtask

    // UART TX stand-in: acknowledges each offered byte after dly cycles and
    // holds busy for hold cycles.
    task automatic collect(input int n, input int dly, input int hold, input int budget);
        int c = 0;
        got.delete();
        while (got.size() < n && c < budget) begin
            if (tx_valid && !tx_busy) begin
                got.push_back(tx_p_data);
                $display("  tx byte %02h", tx_p_data);
                for (int d = 0; d < dly; d++) begin
                    tick;
                    c++;
                end
                tx_busy = 1'b1;
                for (int h = 0; h < hold; h++) begin
                    tick;
                    c++;
                end
                tx_busy = 1'b0;
            end else begin
                tick;
                c++;
            end
        end
    endtask

    task automatic resp_step;
        if (rphase == 0 && tx_valid) begin
            rdly = int'($urandom_range(0, 4));
            rphase = 1;
        end
        if (rphase == 1) begin
            if (rdly == 0) begin
                tx_busy = 1'b1;
                rhold = int'($urandom_range(0, 3));
                rphase = 2;
            end else begin
                rdly--;
            end
        end else if (rphase == 2) begin
            if (rhold == 0) begin
                tx_busy = 1'b0;
                rphase = 0;
            end else begin
                rhold--;
            end
        end
    endtask

    // One cycle of random traffic. The model is a plain byte queue: items
    // are appended whole if they fit, a byte leaves whenever TX acknowledges.
    task automatic model_step(input int a_rate, input int r_rate, input bit en);
        bit av, rv, pop;
        int need, free;
        bit take, drop;
        logic [15:0] ad;
        logic [7:0] rd;
        resp_step();
        av = en && ($urandom_range(0, a_rate) == 0);
        rv = en && ($urandom_range(0, r_rate) == 0);
        ad = 16'($urandom);
        rd = 8'($urandom);
        alu_valid = av;
        alu_out = ad;
        reg_rd_valid = rv;
        reg_rd_data = rd;
        pop = tx_valid && tx_busy;
        if (pop) begin
            if (mq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rnd_ack_on_empty: got ack with model empty, want no ack (t=%0t)", $time);
                pop = 1'b0;
            end else begin
                chk("rnd_data", tx_p_data, mq[0]);
            end
        end
        need = av ? 2 : (rv ? 1 : 0);
        free = DEPTH - mq.size();
        take = (need != 0) && (need <= free);
        drop = (av && rv) || ((need != 0) && !take);
        if (take) begin
            if (av) begin
                mq.push_back(ad[7:0]);
                mq.push_back(ad[15:8]);
            end else begin
                mq.push_back(rd);
            end
        end
        if (pop) void'(mq.pop_front());
        tick;
        chk("rnd_drop", drop_err, drop);
        chk("rnd_full", fifo_full, (DEPTH - mq.size()) < 2);
    endtask

    initial begin
        int r0, d0, len, hi;

        //            r  av  ad        rv  rd     drop full valid cde data
        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 16'h1122, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[2]  = '{1'b0, 1'b1, 16'h3344, 1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 1'b1, 8'h22};
        tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22};
        tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 8'h22};
        tbl[5]  = '{1'b0, 1'b1, 16'h6677, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22};
        tbl[6]  = '{1'b0, 1'b1, 16'h8899, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22};
        tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 8'hAB, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22};
        tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 8'hCD, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h22};
        tbl[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A};

        // Reset state
        tick;
        tick;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_p_data", tx_p_data, 0);
        chk("rst_clk_div_en", clk_div_en, 0);
        chk("rst_fifo_full", fifo_full, 0);
        chk("rst_drop_err", drop_err, 0);
        chk("rst_timeout_err", timeout_err, 0);
        rst = 1'b0;

        // Table vectors, tx_busy stuck low
        for (int i = 0; i < 14; i++) begin
            rst = tbl[i].r;
            alu_valid = tbl[i].av;
            alu_out = tbl[i].ad;
            reg_rd_valid = tbl[i].rv;
            reg_rd_data = tbl[i].rd;
            tx_busy = 1'b0;
            tick;
            $display("vec %0d: drop=%0b full=%0b valid=%0b cde=%0b data=%02h",
                     i, drop_err, fifo_full, tx_valid, clk_div_en, tx_p_data);
            chk($sformatf("tbl%0d_drop", i), drop_err, tbl[i].e_drop);
            chk($sformatf("tbl%0d_full", i), fifo_full, tbl[i].e_full);
            chk($sformatf("tbl%0d_valid", i), tx_valid, tbl[i].e_valid);
            chk($sformatf("tbl%0d_cde", i), clk_div_en, tbl[i].e_cde);
            if (tbl[i].e_valid) chk($sformatf("tbl%0d_data", i), tx_p_data, tbl[i].e_data);
        end
        rst = 1'b0;
        alu_valid = 1'b0;
        reg_rd_valid = 1'b0;

        // Two-byte ALU result, busy after 3 cycles held for 10
        $display("seq alu A55A");
        do_reset(1'b0);
        tick;
        r0 = rise_cnt;
        push_alu(16'hA55A);
        collect(2, 3, 10, 200);
        chk("s1_count", got.size(), 2);
        chk("s1_byte0", got[0], 8'h5A);
        chk("s1_byte1", got[1], 8'hA5);
        chk("s1_rises", rise_cnt - r0, 2);
        tick;
        chk("s1_cde_hold", clk_div_en, 1);
        tick;
        chk("s1_cde_fall", clk_div_en, 0);
        chk("s1_full", fifo_full, 0);

        // Simultaneous reg and ALU items
        $display("seq alu 1234 + reg 3C");
        do_reset(1'b0);
        tick;
        d0 = drop_cnt;
        alu_out = 16'h1234;
        alu_valid = 1'b1;
        reg_rd_data = 8'h3C;
        reg_rd_valid = 1'b1;
        tick;
        alu_valid = 1'b0;
        reg_rd_valid = 1'b0;
        chk("s2_drop_pulse", drop_err, 1);
        collect(3, 1, 2, 80);
        chk("s2_count", got.size(), 2);
        chk("s2_byte0", got[0], 8'h34);
        chk("s2_byte1", got[1], 8'h12);
        chk("s2_drop_once", drop_cnt - d0, 1);

        // Handshake timeout with busy stuck low
        $display("seq timeout");
        do_reset(1'b0);
        tick;
        push_alu(16'hBEEF);
        wait_valid("s3_valid", 5);
        chk("s3_data0", tx_p_data, 8'hEF);
        chk("s3_no_err_yet", timeout_err, 0);
        len = 0;
        while (tx_valid && len < 400) begin
            len++;
            tick;
        end
        chk("s3_valid_len", len, TMO);
        chk("s3_timeout_err", timeout_err, 1);
        wait_valid("s3_next_valid", 5);
        chk("s3_data1", tx_p_data, 8'hBE);
        tick;
        tick;
        chk("s3_sticky", timeout_err, 1);
        do_reset(1'b0);
        tick;
        chk("s3_err_cleared", timeout_err, 0);

        // Busy high across reset release
        $display("seq stale busy");
        do_reset(1'b1);
        tick;
        push_reg(8'hFF);
        hi = 0;
        for (int k = 0; k < 8; k++) begin
            tick;
            if (tx_valid) hi++;
        end
        chk("s4_no_valid_while_busy", hi, 0);
        chk("s4_cde", clk_div_en, 1);
        tx_busy = 1'b0;
        wait_valid("s4_valid", 5);
        chk("s4_data", tx_p_data, 8'hFF);

        // Reset in SEND with 3 bytes queued
        $display("seq reset mid-send");
        do_reset(1'b0);
        tick;
        push_reg(8'h01);
        push_reg(8'h02);
        push_reg(8'h03);
        wait_valid("s5_valid", 5);
        rst = 1'b1;
        tick;
        chk("s5_valid", tx_valid, 0);
        chk("s5_cde", clk_div_en, 0);
        chk("s5_full", fifo_full, 0);
        rst = 1'b0;
        r0 = rise_cnt;
        collect(1, 1, 2, 30);
        chk("s5_no_bytes", got.size(), 0);
        chk("s5_no_rises", rise_cnt - r0, 0);

        // Pop at the pointer wrap with a same-cycle ALU push at count 6
        $display("seq wrap");
        do_reset(1'b0);
        tick;
        push_alu(16'h0201);
        push_alu(16'h0403);
        push_alu(16'h0605);
        push_reg(8'h07);
        collect(7, 0, 1, 200);
        chk("s6a_count", got.size(), 7);
        for (int k = 0; k < 7; k++) chk($sformatf("s6a_byte%0d", k), got[k], 8'(k + 1));
        push_alu(16'h0908);
        push_alu(16'h0B0A);
        push_alu(16'h0D0C);
        wait_valid("s6_valid", 5);
        chk("s6_head", tx_p_data, 8'h08);
        tx_busy = 1'b1;
        alu_out = 16'h0F0E;
        alu_valid = 1'b1;
        tick;
        alu_valid = 1'b0;
        chk("s6_no_drop", drop_err, 0);
        chk("s6_full", fifo_full, 1);
        tick;
        tx_busy = 1'b0;
        collect(7, 1, 1, 300);
        chk("s6b_count", got.size(), 7);
        for (int k = 0; k < 7; k++) chk($sformatf("s6b_byte%0d", k), got[k], 8'(k + 9));

        // Randomized traffic against the queue model
        $display("seq random");
        do_reset(1'b0);
        mq.delete();
        rphase = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (((cyc / 500) % 2) == 0) model_step(5, 4, 1'b1);
            else                        model_step(40, 30, 1'b1);
        end
        for (int cyc = 0; cyc < 300; cyc++) model_step(1, 1, 1'b0);
        chk("rnd_drained", mq.size(), 0);
        chk("rnd_idle_valid", tx_valid, 0);
        chk("rnd_idle_cde", clk_div_en, 0);
        chk("rnd_no_timeout", timeout_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
